noc_router_buf: RTL and testbench

NOC_ROUTER_BUF -- requirements
Module: noc_router_buf

---
 rtl/noc_pkg.sv | 24 ++
 rtl/noc_fifo.sv | 57 +++++
 rtl/noc_router_buf.sv | 134 +++++++++++++
 tb/tb_noc_router_buf.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared constants for the buffered 5-port XY mesh router: port indices,
// destination field layout and the round-robin pointer helper.
package noc_pkg;
    localparam int NUM_PORTS = 5;
    localparam int PORT_N    = 0;
    localparam int PORT_E    = 1;
    localparam int PORT_S    = 2;
    localparam int PORT_W    = 3;
    localparam int PORT_PE   = 4;

    localparam int DEST_W = 4;
    localparam int DX_HI  = 3;
    localparam int DX_LO  = 2;
    localparam int DY_HI  = 1;
    localparam int DY_LO  = 0;

    localparam logic [1:0] COORD_INVALID = 2'd3;

    typedef logic [2:0] port_idx_t;

    function automatic port_idx_t rr_next(input port_idx_t i);
        return (i == port_idx_t'(NUM_PORTS - 1)) ? port_idx_t'(0) : i + port_idx_t'(1);
    endfunction
endpackage

// File: rtl/noc_fifo.sv
// Per-input flit FIFO; push is ignored when full and pop when empty.
// Power-of-two depth so the pointers wrap without compare logic.
module noc_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/noc_router_buf.sv
// Input-buffered 5-port XY router: per-input FIFOs, XY route compute on the
// FIFO heads, per-output round-robin arbiters feeding one output register.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid/data hold until then, and ready never depends on valid in the same cycle.
module noc_router_buf
    import noc_pkg::*;
#(
    parameter logic [3:0] ADDRESS    = 4'b0000,
    parameter int         DATA_W     = 32,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_PORTS-1:0]          in_valid,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
    output logic [NUM_PORTS-1:0]          in_ready,
    output logic [NUM_PORTS-1:0]          out_valid,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data,
    input  logic [NUM_PORTS-1:0]          out_ready,
    output logic [NUM_PORTS-1:0]          error
);
    localparam logic [1:0] MY_X = ADDRESS[DX_HI:DX_LO];
    localparam logic [1:0] MY_Y = ADDRESS[DY_HI:DY_LO];

    logic [NUM_PORTS-1:0]                 fifo_full, fifo_empty, fifo_pop, head_bad;
    logic [NUM_PORTS-1:0][DATA_W-1:0]     head_data;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  req;    // req[out][in]
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  gnt_t;  // gnt_t[in][out]

    assign in_ready = {NUM_PORTS{enable & ~reset}} & ~fifo_full;
    assign error    = {NUM_PORTS{enable}} & head_bad;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
        logic [DATA_W-1:0]    head;
        logic [DEST_W-1:0]    dest;
        logic [1:0]           dx, dy;
        logic [NUM_PORTS-1:0] route_l;
        logic                 bad;

        noc_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (in_valid[p] & in_ready[p]),
            .wdata (in_data[p*DATA_W +: DATA_W]),
            .pop   (fifo_pop[p]),
            .full  (fifo_full[p]),
            .empty (fifo_empty[p]),
            .head  (head)
        );

        assign dest = head[DATA_W-1 -: DEST_W];
        assign dx   = dest[DX_HI:DX_LO];
        assign dy   = dest[DY_HI:DY_LO];

        always_comb begin
            route_l = '0;
            bad     = 1'b0;
            if (dx == COORD_INVALID || dy == COORD_INVALID) bad = 1'b1;
            else if (dx > MY_X) route_l[PORT_E]  = 1'b1;
            else if (dx < MY_X) route_l[PORT_W]  = 1'b1;
            else if (dy > MY_Y) route_l[PORT_N]  = 1'b1;
            else if (dy < MY_Y) route_l[PORT_S]  = 1'b1;
            else                route_l[PORT_PE] = 1'b1;
        end

        assign head_data[p] = head;
        assign head_bad[p]  = ~fifo_empty[p] & bad;
        // A dropped invalid head never requests, so it costs no arbitration slot.
        assign fifo_pop[p]  = enable & (head_bad[p] | (|gnt_t[p]));

        for (genvar o = 0; o < NUM_PORTS; o++) begin : g_req
            assign req[o][p] = ~fifo_empty[p] & route_l[o];
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        port_idx_t            ptr_q, ptr_d, win;
        logic                 found, can_load;
        logic [NUM_PORTS-1:0] gnt_l;
        logic                 valid_q, valid_d;
        logic [DATA_W-1:0]    data_q, data_d;
        int                   idx;

        assign can_load = enable & (~valid_q | out_ready[o]);

        always_comb begin
            found = 1'b0;
            win   = '0;
            idx   = 0;
            gnt_l = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                if (!found && req[o][idx]) begin
                    found = 1'b1;
                    win   = port_idx_t'(idx);
                end
            end
            if (can_load && found) gnt_l[win] = 1'b1;
        end

        always_comb begin
            ptr_d   = (can_load && found) ? rr_next(win) : ptr_q;
            valid_d = valid_q;
            data_d  = data_q;
            if (can_load && found) begin
                valid_d = 1'b1;
                data_d  = head_data[win];
            end else if (enable && out_ready[o]) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ptr_q   <= '0;
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                ptr_q   <= ptr_d;
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign out_valid[o]                  = valid_q;
        assign out_data[o*DATA_W +: DATA_W]  = data_q;

        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_gnt
            assign gnt_t[p][o] = gnt_l[p];
        end
    end
endmodule

// File: tb/tb_noc_router_buf.sv
// Directed bench for noc_router_buf at ADDRESS=0101 (x=1, y=1): single flits,
// contention, backpressure, invalid destination, freeze and async reset.
module tb_noc_router_buf;
    localparam int DW = 32;
    localparam int NP = 5;
    localparam int P_N = 0, P_E = 1, P_S = 2, P_W = 3, P_PE = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NP-1:0]     in_valid, in_ready, out_valid, out_ready, error;
    logic [NP*DW-1:0]  in_data, out_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    noc_router_buf #(.ADDRESS(4'b0101), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .error     (error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input int p, input logic [DW-1:0] d);
        in_valid[p]            = 1'b1;
        in_data[p*DW +: DW]    = d;
    endtask

    task automatic undrive(input int p);
        in_valid[p]            = 1'b0;
        in_data[p*DW +: DW]    = '0;
    endtask

    function automatic logic [DW-1:0] out_word(input int p);
        return out_data[p*DW +: DW];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int accepts, first_block, got;
        logic rdy;

        reset     = 1'b1;
        enable    = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '1;
        step();
        step();
        sample();
        check("rst_in_ready", in_ready, 5'b00000);
        check("rst_out_valid", out_valid, 5'b00000);
        check("rst_out_data", out_data, '0);
        check("rst_error", error, 5'b00000);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b1;
        sample();
        check("idle_in_ready", in_ready, 5'b11111);

        // Dest 0001 (dx=0 < x=1) routes W: a U-turn back out the arrival port.
        drive(P_W, 32'h1A00_0001);
        step();
        undrive(P_W);
        sample();
        check("single_not_early", out_valid, 5'b00000);
        step();
        sample();
        check("single_w_valid", out_valid, 5'b01000);
        check("single_w_data", out_word(P_W), 32'h1A00_0001);
        step();
        sample();
        check("single_w_drained", out_valid, 5'b00000);

        // Dest 0100 (dx=1, dy=0 < y=1) routes S.
        drive(P_W, 32'h4A00_0001);
        step();
        undrive(P_W);
        step();
        sample();
        check("single_s_valid", out_valid, 5'b00100);
        check("single_s_data", out_word(P_S), 32'h4A00_0001);

        // Three inputs contend for PE; pointer starts at N.
        sample();
        drive(P_N, 32'h5000_00A0);
        drive(P_E, 32'h5000_00B1);
        drive(P_W, 32'h5000_00C3);
        step();
        undrive(P_N);
        undrive(P_E);
        undrive(P_W);
        step();
        sample();
        check("cont_1_valid", out_valid, 5'b10000);
        check("cont_1_from_n", out_word(P_PE), 32'h5000_00A0);
        step();
        sample();
        check("cont_2_from_e", out_word(P_PE), 32'h5000_00B1);
        step();
        sample();
        check("cont_3_from_w", out_word(P_PE), 32'h5000_00C3);
        step();
        sample();
        check("cont_done", out_valid, 5'b00000);

        // Last grant was W, so PE now has highest priority over N.
        drive(P_N,  32'h5000_00D0);
        drive(P_PE, 32'h5000_00E4);
        step();
        undrive(P_N);
        undrive(P_PE);
        step();
        sample();
        check("rr_first_pe", out_word(P_PE), 32'h5000_00E4);
        step();
        sample();
        check("rr_second_n", out_word(P_PE), 32'h5000_00D0);
        step();

        // Backpressure on E: dest 1001 routes E.
        out_ready[P_E] = 1'b0;
        accepts     = 0;
        first_block = -1;
        drive(P_W, 32'h9000_0000);
        for (int cyc = 0; cyc < 20 && accepts < 6; cyc++) begin
            sample();
            rdy = in_ready[P_W];
            if (!rdy && first_block < 0) first_block = accepts;
            @(posedge clk);
            #1;
            if (rdy) begin
                exp_q.push_back(32'h9000_0000 + DW'(accepts));
                accepts++;
                drive(P_W, 32'h9000_0000 + DW'(accepts));
            end
        end
        undrive(P_W);
        check("bp_block_point", 64'(first_block), 64'd5);
        check("bp_accepts", 64'(accepts), 64'd5);
        sample();
        check("bp_in_ready_low", in_ready[P_W], 1'b0);
        check("bp_held_valid", out_valid[P_E], 1'b1);
        check("bp_held_data", out_word(P_E), 32'h9000_0000);
        out_ready[P_E] = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (out_valid[P_E]) begin
                if (exp_q.size() == 0) check("bp_extra_flit", out_word(P_E), '0);
                else check("bp_order", out_word(P_E), exp_q.pop_front());
                got++;
            end
            sample();
        end
        check("bp_count", 64'(got), 64'd5);

        // Dest 1100 has dx=3: dropped with a one-cycle error pulse.
        drive(P_PE, 32'hC000_0000);
        step();
        undrive(P_PE);
        sample();
        check("inv_error_pulse", error, 5'b10000);
        check("inv_no_out", out_valid, 5'b00000);
        step();
        sample();
        check("inv_error_clear", error, 5'b00000);
        check("inv_still_no_out", out_valid, 5'b00000);

        // Freeze: flit 77 held on N output, 88 buffered behind it.
        out_ready[P_N] = 1'b0;
        drive(P_PE, 32'h6000_0077);
        step();
        drive(P_PE, 32'h6000_0088);
        step();
        undrive(P_PE);
        sample();
        check("frz_loaded", out_word(P_N), 32'h6000_0077);
        enable         = 1'b0;
        out_ready[P_N] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            sample();
            check("frz_valid_held", out_valid, 5'b00001);
            check("frz_data_held", out_word(P_N), 32'h6000_0077);
            check("frz_in_ready", in_ready, 5'b00000);
        end
        enable = 1'b1;
        step();
        out_ready[P_N] = 1'b0;
        sample();
        check("frz_next_is_88", out_word(P_N), 32'h6000_0088);
        drive(P_PE, 32'h6000_0099);
        step();
        undrive(P_PE);
        sample();
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 5'b00000);
        check("arst_out_data", out_data, '0);
        check("arst_in_ready", in_ready, 5'b00000);
        step();
        step();
        reset     = 1'b0;
        out_ready = '1;
        step();
        step();
        step();
        sample();
        check("arst_fifos_empty", out_valid, 5'b00000);
        check("arst_in_ready_back", in_ready, 5'b11111);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
